// File: rtl/wb_master_arbiter_pkg.sv
// Shared Wishbone widths and arbiter state encoding for the master arbiter.
package wb_master_arbiter_pkg;

    localparam int unsigned WB_DW = 32;
    localparam int unsigned WB_AW = 32;

    typedef enum logic {
        ARB_IDLE = 1'b0,
        ARB_BUSY = 1'b1
    } arb_state_e;

endpackage

// File: rtl/wb_master_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request at or after ptr, wrapping.
module wb_master_arbiter_rr_pick
    import wb_master_arbiter_pkg::*;
#(
    parameter int unsigned NM = 2,
    parameter int unsigned PW = (NM > 1) ? $clog2(NM) : 1
) (
    input  logic [NM-1:0] req,
    input  logic [PW-1:0] ptr,
    output logic [NM-1:0] pick,
    output logic [PW-1:0] pick_idx
);

    logic          found;
    logic [PW-1:0] j;

    always_comb begin
        pick     = '0;
        pick_idx = '0;
        found    = 1'b0;
        j        = '0;
        for (int unsigned k = 0; k < NM; k++) begin
            j = PW'((32'(ptr) + k) % NM);
            if (!found && req[j]) begin
                found    = 1'b1;
                pick[j]  = 1'b1;
                pick_idx = j;
            end
        end
    end

endmodule

// File: rtl/wb_master_arbiter.sv
// Round-robin arbiter sharing one Wishbone master port among NM masters,
// with a per-transaction watchdog that aborts stalled transfers with ERR.
module wb_master_arbiter
    import wb_master_arbiter_pkg::*;
#(
    parameter int unsigned NM      = 2,
    parameter int unsigned TIMEOUT = 255
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NM-1:0]       m_STB,
    input  logic [NM-1:0]       m_WE,
    input  logic [WB_AW*NM-1:0] m_ADDR,
    input  logic [WB_DW*NM-1:0] m_DAT_I,
    output logic [WB_DW*NM-1:0] m_DAT_O,
    output logic [NM-1:0]       m_ACK,
    output logic [NM-1:0]       m_ERR,
    output logic                bus_STB,
    output logic                bus_WE,
    output logic [WB_AW-1:0]    bus_ADDR,
    output logic [WB_DW-1:0]    bus_DAT_O,
    input  logic [WB_DW-1:0]    bus_DAT_I,
    input  logic                bus_ACK,
    output logic [NM-1:0]       gnt
);

    localparam int unsigned PW  = (NM > 1) ? $clog2(NM) : 1;
    localparam int unsigned WDW = $clog2(TIMEOUT + 1);

    arb_state_e     state;
    logic [PW-1:0]  gnt_idx;
    logic [PW-1:0]  ptr;
    logic [PW-1:0]  next_ptr;
    logic [WDW-1:0] wdog;
    logic [NM-1:0]  pick;
    logic [PW-1:0]  pick_idx;

    wb_master_arbiter_rr_pick #(
        .NM (NM),
        .PW (PW)
    ) u_rr_pick (
        .req      (m_STB),
        .ptr      (ptr),
        .pick     (pick),
        .pick_idx (pick_idx)
    );

    assign next_ptr = (gnt_idx == PW'(NM - 1)) ? '0 : gnt_idx + PW'(1);

    // Arbitration FSM; every BUSY exit returns to IDLE for at least one cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= ARB_IDLE;
            gnt     <= '0;
            gnt_idx <= '0;
            ptr     <= '0;
            wdog    <= '0;
            m_ERR   <= '0;
        end else begin
            m_ERR <= '0;
            case (state)
                ARB_IDLE: begin
                    wdog <= '0;
                    if (|m_STB) begin
                        state   <= ARB_BUSY;
                        gnt     <= pick;
                        gnt_idx <= pick_idx;
                    end
                end
                ARB_BUSY: begin
                    if (bus_ACK || !m_STB[gnt_idx] || (wdog == WDW'(TIMEOUT - 1))) begin
                        state <= ARB_IDLE;
                        gnt   <= '0;
                        ptr   <= next_ptr;
                        wdog  <= '0;
                        if (!bus_ACK && m_STB[gnt_idx]) begin
                            m_ERR <= gnt;
                        end
                    end else begin
                        wdog <= wdog + WDW'(1);
                    end
                end
                default: begin
                    state <= ARB_IDLE;
                    gnt   <= '0;
                end
            endcase
        end
    end

    // Bus mux and ACK demux driven from the registered grant; all zero when idle.
    always_comb begin
        bus_STB   = 1'b0;
        bus_WE    = 1'b0;
        bus_ADDR  = '0;
        bus_DAT_O = '0;
        m_ACK     = '0;
        for (int unsigned i = 0; i < NM; i++) begin
            if (gnt[i]) begin
                bus_STB   = m_STB[i];
                bus_WE    = m_WE[i];
                bus_ADDR  = m_ADDR[WB_AW*i +: WB_AW];
                bus_DAT_O = m_DAT_I[WB_DW*i +: WB_DW];
                m_ACK[i]  = bus_ACK;
            end
        end
    end

    assign m_DAT_O = {NM{bus_DAT_I}};

endmodule
